dmem_ctrl: RTL

//   Data-memory controller directly downstream of the load/store stage.
//   - Accepts one access per request: address, write data, byte-lane enables.
//   - Steers bytes onto the lanes selected by addr[1:0] and writes a word-organised RAM.
//   - Returns read data right-justified (addressed byte or halfword in bits [7:0]/[15:0]),

---
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Word-organised data-memory controller for the load/store stage: byte-lane steering,
// right-justified load data, misalignment detection and a fixed programmable wait latency.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [3:0]  req_byte_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH+1:0] addr_q;
  logic                  write_q;
  logic [3:0]            byte_we_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic [1:0]            offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            load_lanes;
  logic [3:0]            lanes;
  logic [7:0]            lane_mask;
  logic                  misaligned;
  logic [31:0]           wdata_steer;
  logic [31:0]           rdata_shift;
  logic                  do_write;

  // Address bits above the RAM index alias onto the same words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen from accept until the controller is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      byte_we_q <= 4'd0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
    end else if (accept) begin
      addr_q    <= req_addr[ADDR_WIDTH+1:0];
      write_q   <= req_write;
      byte_we_q <= req_byte_we;
      size_q    <= req_size;
      wdata_q   <= req_wdata;
    end
  end

  assign offset   = addr_q[1:0];
  assign word_idx = addr_q[ADDR_WIDTH+1:2];

  always_comb begin
    load_lanes = 4'b1111;
    unique case (size_q)
      2'd0:    load_lanes = 4'b0001;
      2'd1:    load_lanes = 4'b0011;
      default: load_lanes = 4'b1111;
    endcase
  end

  // Any lane pushed past byte 3 by the offset means the access straddles a word.
  assign lanes       = write_q ? byte_we_q : load_lanes;
  assign lane_mask   = {4'b0000, lanes} << offset;
  assign misaligned  = |lane_mask[7:4];
  assign wdata_steer = wdata_q << {offset, 3'b000};
  assign rdata_shift = mem[word_idx] >> {offset, 3'b000};
  assign do_write    = (state_q == ACCESS) && write_q && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state_q == ACCESS);
      if (state_q == ACCESS) begin
        rsp_err   <= misaligned;
        rsp_rdata <= (write_q || misaligned) ? 32'd0 : rdata_shift;
      end
    end
  end

  // RAM array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_mask[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_steer[8*k +: 8];
        end
      end
    end
  end

endmodule
